// File: rtl/mac_window_ctrl_if.sv
// mac_window_ctrl_if: start/status, buffer read, MAC and result-stream signals of
// mac_window_ctrl. Signal suffixes are from the controller's point of view.
// master = window controller, slave = buffers / MAC / output FIFO side.
interface mac_window_ctrl_if #(
    parameter int INPUT_BIT_RESOLUTION  = 8,
    parameter int OUTPUT_BIT_RESOLUTION = 32,
    parameter int FMAP_ADDR_W           = 6,
    parameter int KERN_ADDR_W           = 4
);
    logic                                    start_i;
    logic signed [OUTPUT_BIT_RESOLUTION-1:0] bias_i;
    logic                                    busy_o;
    logic                                    done_o;
    logic        [FMAP_ADDR_W-1:0]           fmap_addr_o;
    logic                                    fmap_rd_o;
    logic signed [INPUT_BIT_RESOLUTION-1:0]  fmap_data_i;
    logic        [KERN_ADDR_W-1:0]           kern_addr_o;
    logic signed [INPUT_BIT_RESOLUTION-1:0]  kern_data_i;
    logic                                    mac_valid_o;
    logic signed [INPUT_BIT_RESOLUTION-1:0]  mac_fin_data_o;
    logic signed [INPUT_BIT_RESOLUTION-1:0]  mac_kernel_data_o;
    logic signed [OUTPUT_BIT_RESOLUTION-1:0] mac_bias_o;
    logic                                    mac_ready_o;
    logic                                    mac_res_valid_i;
    logic signed [OUTPUT_BIT_RESOLUTION-1:0] mac_res_i;
    logic                                    out_valid_o;
    logic signed [OUTPUT_BIT_RESOLUTION-1:0] out_data_o;
    logic                                    out_ready_i;

    modport master (
        input  start_i, bias_i, fmap_data_i, kern_data_i, mac_res_valid_i, mac_res_i, out_ready_i,
        output busy_o, done_o, fmap_addr_o, fmap_rd_o, kern_addr_o, mac_valid_o,
               mac_fin_data_o, mac_kernel_data_o, mac_bias_o, mac_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        output start_i, bias_i, fmap_data_i, kern_data_i, mac_res_valid_i, mac_res_i, out_ready_i,
        input  busy_o, done_o, fmap_addr_o, fmap_rd_o, kern_addr_o, mac_valid_o,
               mac_fin_data_o, mac_kernel_data_o, mac_bias_o, mac_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/mac_window_ctrl.sv
// mac_window_ctrl: walks a KxK stride-1 window over a W x H feature map, streams the
// K*K (pixel, weight) pairs into one MAC and forwards each MAC result in raster order.
// Optional build macro MAC_CTRL_RELU_EN clamps negative results to zero.
module mac_window_ctrl #(
    parameter int INPUT_BIT_RESOLUTION  = 8,
    parameter int OUTPUT_BIT_RESOLUTION = 32,
    parameter int KERNEL_SIZE           = 3,
    parameter int FMAP_WIDTH            = 8,
    parameter int FMAP_HEIGHT           = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mac_window_ctrl_if.master bus
);
    localparam int K    = KERNEL_SIZE;
    localparam int W    = FMAP_WIDTH;
    localparam int H    = FMAP_HEIGHT;
    localparam int OBR  = OUTPUT_BIT_RESOLUTION;
    localparam int FA_W = (W * H > 1) ? $clog2(W * H) : 1;
    localparam int KA_W = (K * K > 1) ? $clog2(K * K) : 1;
    localparam int KC_W = $clog2(K) + 1;
    localparam int OC_W = $clog2(W) + 1;
    localparam int OR_W = $clog2(H) + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RES,
        OUT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KC_W-1:0] kr_q, kr_d;
    logic [KC_W-1:0] kc_q, kc_d;
    logic [OR_W-1:0] orow_q, orow_d;
    logic [OC_W-1:0] ocol_q, ocol_d;
    logic [OBR-1:0]  bias_q, bias_d;
    logic [OBR-1:0]  res_q, res_d;
    logic            mac_valid_q;
    logic [OBR-1:0]  res_filt;
    logic            fetching;
    logic            last_kc;
    logic            last_kr;
    logic            last_col;
    logic            last_row;

    assign fetching = (state_q == FETCH);
    assign last_kc  = (kc_q == KC_W'(K - 1));
    assign last_kr  = (kr_q == KC_W'(K - 1));
    assign last_col = (ocol_q == OC_W'(W - K));
    assign last_row = (orow_q == OR_W'(H - K));

`ifdef MAC_CTRL_RELU_EN
    // Clamp negative MAC results to zero before they are captured for the output stream
    always_comb res_filt = bus.mac_res_i[OBR-1] ? '0 : bus.mac_res_i;
`else
    // Pass MAC results through unchanged
    always_comb res_filt = bus.mac_res_i;
`endif

    // Next-state logic: tap counters in FETCH, result capture, window stepping on handshake
    always_comb begin
        state_d = state_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        bias_d  = bias_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    bias_d  = bus.bias_i;
                    kr_d    = '0;
                    kc_d    = '0;
                    orow_d  = '0;
                    ocol_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (last_kc) begin
                    kc_d = '0;
                    if (last_kr) begin
                        kr_d    = '0;
                        state_d = WAIT_RES;
                    end else begin
                        kr_d = kr_q + 1'b1;
                    end
                end else begin
                    kc_d = kc_q + 1'b1;
                end
            end
            WAIT_RES: begin
                if (bus.mac_res_valid_i) begin
                    res_d   = res_filt;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready_i) begin
                    if (last_col) begin
                        ocol_d = '0;
                        if (last_row) begin
                            state_d = DONE;
                        end else begin
                            orow_d  = orow_q + 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        ocol_d  = ocol_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and captured values; reset drops any run in progress
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            kr_q        <= '0;
            kc_q        <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            bias_q      <= '0;
            res_q       <= '0;
            mac_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            bias_q      <= bias_d;
            res_q       <= res_d;
            mac_valid_q <= fetching;
        end
    end

    // The buffers register their read data, so it is forwarded to the MAC in the cycle
    // after the read, alongside mac_valid_o, and held at zero otherwise.
    assign bus.fmap_rd_o         = fetching;
    assign bus.fmap_addr_o       = fetching ? FA_W'((32'(orow_q) + 32'(kr_q)) * 32'(W)
                                                    + 32'(ocol_q) + 32'(kc_q)) : '0;
    assign bus.kern_addr_o       = fetching ? KA_W'(32'(kr_q) * 32'(K) + 32'(kc_q)) : '0;
    assign bus.mac_valid_o       = mac_valid_q;
    assign bus.mac_fin_data_o    = mac_valid_q ? bus.fmap_data_i : '0;
    assign bus.mac_kernel_data_o = mac_valid_q ? bus.kern_data_i : '0;
    assign bus.mac_bias_o        = bias_q;
    assign bus.mac_ready_o       = (state_q == WAIT_RES);
    assign bus.out_valid_o       = (state_q == OUT);
    assign bus.out_data_o        = res_q;
    assign bus.busy_o            = (state_q != IDLE);
    assign bus.done_o            = (state_q == DONE);
endmodule

// File: tb/tb_mac_window_ctrl.sv
// tb_mac_window_ctrl: two controllers (4x4 map and 3x3 map, both K=3) with behavioural
// buffers and MAC; expected results are queued at stimulus time and popped by monitors.
`timescale 1ns/1ps
module tb_mac_window_ctrl;
    localparam int IBR = 8;
    localparam int OBR = 32;

`ifdef MAC_CTRL_RELU_EN
    localparam longint NegExp = 0;
`else
    localparam longint NegExp = -9;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mac_window_ctrl_if #(.INPUT_BIT_RESOLUTION(IBR), .OUTPUT_BIT_RESOLUTION(OBR),
                         .FMAP_ADDR_W(4), .KERN_ADDR_W(4)) busA ();
    mac_window_ctrl_if #(.INPUT_BIT_RESOLUTION(IBR), .OUTPUT_BIT_RESOLUTION(OBR),
                         .FMAP_ADDR_W(4), .KERN_ADDR_W(4)) busB ();

    mac_window_ctrl #(.INPUT_BIT_RESOLUTION(IBR), .OUTPUT_BIT_RESOLUTION(OBR), .KERNEL_SIZE(3),
                      .FMAP_WIDTH(4), .FMAP_HEIGHT(4)) dutA (.clk_i(clk), .rst_ni(rst_n), .bus(busA));
    mac_window_ctrl #(.INPUT_BIT_RESOLUTION(IBR), .OUTPUT_BIT_RESOLUTION(OBR), .KERNEL_SIZE(3),
                      .FMAP_WIDTH(3), .FMAP_HEIGHT(3)) dutB (.clk_i(clk), .rst_ni(rst_n), .bus(busB));

    logic signed [IBR-1:0] fmapA [16];
    logic signed [IBR-1:0] kernA [16];
    logic signed [IBR-1:0] fmapB [16];
    logic signed [IBR-1:0] kernB [16];

    longint expA[$];
    longint expB[$];
    int     addrLogA[$];
    int     hsA = 0, hsB = 0, doneA = 0, doneB = 0;
    logic   stallSeenA = 1'b0;
    longint stallDataA = 0;

    longint accA = 0, accB = 0, prodA, prodB;
    int     cntA = 0, cntB = 0;

    // One comparison: counts it, reports a FAIL line on mismatch
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Synchronous-read buffers: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (busA.fmap_rd_o) begin
            busA.fmap_data_i <= fmapA[busA.fmap_addr_o];
            busA.kern_data_i <= kernA[busA.kern_addr_o];
        end
        if (busB.fmap_rd_o) begin
            busB.fmap_data_i <= fmapB[busB.fmap_addr_o];
            busB.kern_data_i <= kernB[busB.kern_addr_o];
        end
    end

    // Behavioural MAC for DUT A: accumulate 9 pairs, add bias, offer result until ready
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accA <= 0;
            cntA <= 0;
            busA.mac_res_valid_i <= 1'b0;
            busA.mac_res_i <= '0;
        end else begin
            if (busA.mac_res_valid_i && busA.mac_ready_o) busA.mac_res_valid_i <= 1'b0;
            if (busA.mac_valid_o) begin
                prodA = longint'(busA.mac_fin_data_o) * longint'(busA.mac_kernel_data_o);
                if (cntA == 8) begin
                    busA.mac_res_i <= OBR'(accA + prodA + longint'(busA.mac_bias_o));
                    busA.mac_res_valid_i <= 1'b1;
                    accA <= 0;
                    cntA <= 0;
                end else begin
                    accA <= accA + prodA;
                    cntA <= cntA + 1;
                end
            end
        end
    end

    // Behavioural MAC for DUT B
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accB <= 0;
            cntB <= 0;
            busB.mac_res_valid_i <= 1'b0;
            busB.mac_res_i <= '0;
        end else begin
            if (busB.mac_res_valid_i && busB.mac_ready_o) busB.mac_res_valid_i <= 1'b0;
            if (busB.mac_valid_o) begin
                prodB = longint'(busB.mac_fin_data_o) * longint'(busB.mac_kernel_data_o);
                if (cntB == 8) begin
                    busB.mac_res_i <= OBR'(accB + prodB + longint'(busB.mac_bias_o));
                    busB.mac_res_valid_i <= 1'b1;
                    accB <= 0;
                    cntB <= 0;
                end else begin
                    accB <= accB + prodB;
                    cntB <= cntB + 1;
                end
            end
        end
    end

    // Monitor A: scoreboard pops on handshake, hold/no-fetch checks while stalled
    always @(negedge clk) begin
        if (busA.fmap_rd_o) addrLogA.push_back(int'(busA.fmap_addr_o));
        if (busA.done_o) doneA++;
        if (busA.out_valid_o && busA.out_ready_i) begin
            hsA++;
            stallSeenA = 1'b0;
            if (expA.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL resultA actual=%0d required=no result", longint'(busA.out_data_o));
            end else begin
                checkOutput("resultA", longint'(busA.out_data_o), expA.pop_front());
            end
        end else if (busA.out_valid_o) begin
            if (stallSeenA) begin
                checkOutput("stallHoldA", longint'(busA.out_data_o), stallDataA);
            end else begin
                stallSeenA = 1'b1;
                stallDataA = longint'(busA.out_data_o);
            end
            checkOutput("stallNoReadA", longint'(busA.fmap_rd_o), 0);
        end
    end

    // Monitor B: scoreboard pops on handshake
    always @(negedge clk) begin
        if (busB.done_o) doneB++;
        if (busB.out_valid_o && busB.out_ready_i) begin
            hsB++;
            if (expB.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL resultB actual=%0d required=no result", longint'(busB.out_data_o));
            end else begin
                checkOutput("resultB", longint'(busB.out_data_o), expB.pop_front());
            end
        end
    end

    // Fill DUT A's buffers: 0 = all ones, 1 = fmap[i]=i, 2 = all minus one; kernel all ones
    task automatic loadA(input int pattern);
        for (int i = 0; i < 16; i++) begin
            fmapA[i] = (pattern == 0) ? 8'sd1 : (pattern == 1) ? 8'(i) : -8'sd1;
            kernA[i] = 8'sd1;
        end
    endtask

    // One-cycle start pulse with bias; bias input changed afterwards to catch resampling
    task automatic applyStimulus(input int which, input int biasVal);
        @(posedge clk);
        #1;
        if (which == 0) begin busA.bias_i = biasVal; busA.start_i = 1'b1; end
        else            begin busB.bias_i = biasVal; busB.start_i = 1'b1; end
        @(posedge clk);
        #1;
        if (which == 0) begin busA.start_i = 1'b0; busA.bias_i = 1000; end
        else            begin busB.start_i = 1'b0; busB.bias_i = 1000; end
        checkOutput("busyAfterStart", longint'(which == 0 ? busA.busy_o : busB.busy_o), 1);
    endtask

    // Wait for done_o with a cycle budget, then check run bookkeeping
    task automatic finishRun(input int which, input int results, input int hsBase, input int doneBase);
        int n = 0;
        while (n < 600 && !(which == 0 ? busA.done_o : busB.done_o)) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("doneSeen", longint'(which == 0 ? busA.done_o : busB.done_o), 1);
        checkOutput("busyInDone", longint'(which == 0 ? busA.busy_o : busB.busy_o), 1);
        @(negedge clk);
        #1;
        checkOutput("busyAfterDone", longint'(which == 0 ? busA.busy_o : busB.busy_o), 0);
        checkOutput("doneOnePulse", longint'(which == 0 ? busA.done_o : busB.done_o), 0);
        checkOutput("doneCount", longint'((which == 0 ? doneA : doneB) - doneBase), 1);
        checkOutput("resultCount", longint'((which == 0 ? hsA : hsB) - hsBase), longint'(results));
        checkOutput("queueEmpty", longint'(which == 0 ? expA.size() : expB.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hsBase, doneBase, addrBase, n;
        int addrExp[9];
        addrExp = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        busA.start_i = 1'b0; busA.bias_i = '0; busA.out_ready_i = 1'b1;
        busB.start_i = 1'b0; busB.bias_i = '0; busB.out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fmapB[i] = 8'(i);
            kernB[i] = 8'sd2;
        end
        loadA(0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", longint'(busA.busy_o), 0);
        checkOutput("rstDone", longint'(busA.done_o), 0);
        checkOutput("rstRd", longint'(busA.fmap_rd_o), 0);
        checkOutput("rstMacValid", longint'(busA.mac_valid_o), 0);
        checkOutput("rstMacReady", longint'(busA.mac_ready_o), 0);
        checkOutput("rstOutValid", longint'(busA.out_valid_o), 0);
        checkOutput("rstOutData", longint'(busA.out_data_o), 0);
        checkOutput("rstAddr", longint'(busA.fmap_addr_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] run 1: ones, bias 5");
        repeat (4) expA.push_back(14);
        hsBase = hsA; doneBase = doneA;
        applyStimulus(0, 5);
        finishRun(0, 4, hsBase, doneBase);

        $display("[TB] run 2: fmap[i]=i, stall on second result");
        loadA(1);
        expA.push_back(45); expA.push_back(54); expA.push_back(81); expA.push_back(90);
        hsBase = hsA; doneBase = doneA; addrBase = addrLogA.size();
        applyStimulus(0, 0);
        n = 0;
        while (hsA - hsBase < 1 && n < 200) begin @(negedge clk); #1; n++; end
        checkOutput("firstResultSeen", longint'(hsA - hsBase), 1);
        @(posedge clk);
        #1 busA.out_ready_i = 1'b0;
        n = 0;
        while (!busA.out_valid_o && n < 200) begin @(negedge clk); #1; n++; end
        checkOutput("secondResultPresented", longint'(busA.out_valid_o), 1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 busA.out_ready_i = 1'b1;
        finishRun(0, 4, hsBase, doneBase);
        checkOutput("addrLogLen", longint'(addrLogA.size() - addrBase), 36);
        if (addrLogA.size() - addrBase >= 9)
            for (int i = 0; i < 9; i++) checkOutput("addrWindow0", longint'(addrLogA[addrBase + i]), longint'(addrExp[i]));

        $display("[TB] run 3: all minus one");
        loadA(2);
        repeat (4) expA.push_back(NegExp);
        hsBase = hsA; doneBase = doneA;
        applyStimulus(0, 0);
        finishRun(0, 4, hsBase, doneBase);

        $display("[TB] run 4: reset during second window fetch");
        loadA(1);
        expA.push_back(52); expA.push_back(61); expA.push_back(88); expA.push_back(97);
        hsBase = hsA;
        applyStimulus(0, 7);
        n = 0;
        while (!(hsA - hsBase >= 1 && busA.fmap_rd_o) && n < 200) begin @(negedge clk); #1; n++; end
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rdBeforeReset", longint'(busA.fmap_rd_o), 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", longint'(busA.busy_o), 0);
        checkOutput("midRstRd", longint'(busA.fmap_rd_o), 0);
        checkOutput("midRstAddr", longint'(busA.fmap_addr_o), 0);
        checkOutput("midRstKernAddr", longint'(busA.kern_addr_o), 0);
        checkOutput("midRstMacValid", longint'(busA.mac_valid_o), 0);
        checkOutput("midRstOutValid", longint'(busA.out_valid_o), 0);
        checkOutput("midRstOutData", longint'(busA.out_data_o), 0);
        checkOutput("midRstBias", longint'(busA.mac_bias_o), 0);
        expA.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expA.push_back(45); expA.push_back(54); expA.push_back(81); expA.push_back(90);
        hsBase = hsA; doneBase = doneA; addrBase = addrLogA.size();
        applyStimulus(0, 0);
        finishRun(0, 4, hsBase, doneBase);
        if (addrLogA.size() - addrBase >= 4) begin
            checkOutput("restartAddr0", longint'(addrLogA[addrBase]), 0);
            checkOutput("restartAddr3", longint'(addrLogA[addrBase + 3]), 4);
        end else begin
            checkOutput("restartAddrLen", longint'(addrLogA.size() - addrBase), 36);
        end

        $display("[TB] run 5: single window, extra starts while busy");
        expB.push_back(75);
        hsBase = hsB; doneBase = doneB;
        applyStimulus(1, 3);
        for (int p = 0; p < 3; p++) begin
            repeat (2) @(posedge clk);
            #1 busB.start_i = 1'b1; busB.bias_i = 99;
            @(posedge clk);
            #1 busB.start_i = 1'b0;
        end
        checkOutput("biasHeldB", longint'(busB.mac_bias_o), 3);
        finishRun(1, 1, hsBase, doneBase);
        repeat (30) @(negedge clk);
        #1;
        checkOutput("singleRunDoneB", longint'(doneB - doneBase), 1);
        checkOutput("singleRunResultsB", longint'(hsB - hsBase), 1);
        checkOutput("idleAfterB", longint'(busB.busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
